// File: rtl/r_i_type_instructions_pkg.sv
// Shared constants for the R/I-type execute datapath: widths, register file geometry, ALU op codes.
package r_i_type_instructions_pkg;

    localparam int N         = 64;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

endpackage

// File: rtl/r_i_type_instructions_alu_64.sv
// 64-bit combinational ALU: AND/OR/ADD/SUB/SLT/NOR with carry, signed-less-than, overflow and zero flags.
module r_i_type_instructions_alu_64
    import r_i_type_instructions_pkg::*;
(
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [3:0]   op_i,
    output logic [N-1:0] result_o,
    output logic         cout_o,
    output logic         slt_o,
    output logic         overflow_o,
    output logic         zero_o
);

    logic [N:0] sum;
    logic [N:0] diff;
    logic       lt_signed;
    logic       add_ovf;
    logic       sub_ovf;
    logic       op_valid;

    always_comb begin
        sum  = {1'b0, a_i} + {1'b0, b_i};
        // Two's-complement subtract; the carry out of bit N is the inverted borrow.
        diff = {1'b0, a_i} + {1'b0, ~b_i} + {{N{1'b0}}, 1'b1};
        lt_signed = (a_i[N-1] ^ b_i[N-1]) ? a_i[N-1] : diff[N-1];
        add_ovf   = (a_i[N-1] == b_i[N-1]) && (sum[N-1]  != a_i[N-1]);
        sub_ovf   = (a_i[N-1] != b_i[N-1]) && (diff[N-1] != a_i[N-1]);
    end

    always_comb begin
        result_o   = '0;
        cout_o     = 1'b0;
        overflow_o = 1'b0;
        op_valid   = 1'b1;
        case (op_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            ALU_ADD: begin
                result_o   = sum[N-1:0];
                cout_o     = sum[N];
                overflow_o = add_ovf;
            end
            ALU_SUB: begin
                result_o   = diff[N-1:0];
                cout_o     = diff[N];
                overflow_o = sub_ovf;
            end
            ALU_SLT: begin
                result_o = {{(N-1){1'b0}}, lt_signed};
                cout_o   = diff[N];
            end
            default: op_valid = 1'b0;
        endcase
        // Unsupported codes drive every flag low, including zero.
        slt_o  = op_valid && lt_signed;
        zero_o = op_valid && (result_o == '0);
    end

endmodule

// File: rtl/r_i_type_instructions.sv
// Single-cycle R/I-type execute datapath: field decode, 32x64 register file, ALU, write-back.
// Optional build macro RI_REG0_ZERO_EN hard-wires register 0 to zero.
module r_i_type_instructions
    import r_i_type_instructions_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  instruction,
    input  logic [3:0]   ALU_OP,
    input  logic         RegWrite,
    input  logic         RegDst,
    input  logic         ALUSrc,
    input  logic         XO,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         slt,
    output logic         overflow,
    output logic         zero_flag
);

    logic [N-1:0]         regs_q [NUM_REGS];
    logic [REG_IDX_W-1:0] rd1_addr;
    logic [REG_IDX_W-1:0] rd2_addr;
    logic [REG_IDX_W-1:0] wr_addr;
    logic [N-1:0]         rd1_data;
    logic [N-1:0]         rd2_data;
    logic [N-1:0]         imm_ext;
    logic [N-1:0]         operand_b;
    logic [N-1:0]         wr_data_d;
    logic                 wr_en;
    logic                 unused_inputs;

    // Opcode bits are decoded upstream; RegDst is carried on the bus but has no effect here.
    assign unused_inputs = ^{RegDst, instruction[31:26]};

    always_comb begin
        rd1_addr  = XO ? instruction[20:16] : instruction[25:21];
        wr_addr   = XO ? instruction[25:21] : instruction[20:16];
        rd2_addr  = instruction[15:11];
        imm_ext   = {{(N-16){instruction[15]}}, instruction[15:0]};
        rd1_data  = regs_q[rd1_addr];
        rd2_data  = regs_q[rd2_addr];
`ifdef RI_REG0_ZERO_EN
        if (rd1_addr == '0) rd1_data = '0;
        if (rd2_addr == '0) rd2_data = '0;
        wr_en     = RegWrite && (wr_addr != '0);
`else
        wr_en     = RegWrite;
`endif
        operand_b = ALUSrc ? imm_ext : rd2_data;
    end

    r_i_type_instructions_alu_64 u_alu_64 (
        .a_i        (rd1_data),
        .b_i        (operand_b),
        .op_i       (ALU_OP),
        .result_o   (result),
        .cout_o     (cout),
        .slt_o      (slt),
        .overflow_o (overflow),
        .zero_o     (zero_flag)
    );

    assign wr_data_d = result;

    // No read bypass: a same-cycle read of the write target still sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_r_i_type_instructions.sv
// Directed + randomized bench for r_i_type_instructions against an arithmetic reference model.
module tb_r_i_type_instructions;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic [3:0]  ALU_OP;
    logic        RegWrite;
    logic        RegDst;
    logic        ALUSrc;
    logic        XO;
    logic [63:0] result;
    logic        cout;
    logic        slt;
    logic        overflow;
    logic        zero_flag;

    r_i_type_instructions dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .ALU_OP      (ALU_OP),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrc      (ALUSrc),
        .XO          (XO),
        .result      (result),
        .cout        (cout),
        .slt         (slt),
        .overflow    (overflow),
        .zero_flag   (zero_flag)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

    logic [63:0] mdl [32];
    int          total = 0;
    int          bad   = 0;
    int          txn   = 0;
    logic [63:0] last_res;
    logic        last_cout, last_ovf, last_zero;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rd(input logic [4:0] idx);
`ifdef RI_REG0_ZERO_EN
        if (idx == 5'd0) return 64'd0;
`endif
        return mdl[idx];
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] f25, input logic [4:0] f20, input logic [15:0] lo);
        return {6'b0, f25, f20, lo};
    endfunction

    // Reference behaviour expressed as plain arithmetic on values.
    task automatic model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic c, output logic s,
                         output logic ov, output logic z);
        logic signed [65:0] wide;
        logic valid;
        valid = 1'b1;
        c = 1'b0;
        ov = 1'b0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_NOR: r = ~(a | b);
            OP_ADD: begin
                r    = a + b;
                c    = (r < a);
                wide = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
                ov   = (wide > SMAX) || (wide < SMIN);
            end
            OP_SUB: begin
                r    = a - b;
                c    = (a >= b);
                wide = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
                ov   = (wide > SMAX) || (wide < SMIN);
            end
            OP_SLT: begin
                r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                c = (a >= b);
            end
            default: begin
                r = 64'd0;
                valid = 1'b0;
            end
        endcase
        s = valid && ($signed(a) < $signed(b));
        z = valid && (r == 64'd0);
    endtask

    task automatic step(input logic rst_v, input logic [31:0] ins, input logic [3:0] op,
                        input logic src, input logic xo, input logic we, input string tag);
        logic [63:0] a, b, r;
        logic c, s, ov, z;
        logic [4:0] wa;
        rst = rst_v; instruction = ins; ALU_OP = op;
        ALUSrc = src; XO = xo; RegWrite = we; RegDst = 1'($urandom);
        a  = rd(xo ? ins[20:16] : ins[25:21]);
        b  = src ? {{48{ins[15]}}, ins[15:0]} : rd(ins[15:11]);
        wa = xo ? ins[25:21] : ins[20:16];
        model(op, a, b, r, c, s, ov, z);
        @(negedge clk);
        chk({tag, ".result"}, result, r);
        chk({tag, ".cout"}, 64'(cout), 64'(c));
        chk({tag, ".overflow"}, 64'(overflow), 64'(ov));
        chk({tag, ".slt"}, 64'(slt), 64'(s));
        chk({tag, ".zero"}, 64'(zero_flag), 64'(z));
        last_res = result; last_cout = cout; last_ovf = overflow; last_zero = zero_flag;
        $display("txn %0d %s rst=%0d op=%h we=%0d res=%h", txn, tag, rst_v, op, we, result);
        txn++;
        @(posedge clk);
        if (rst_v) begin
            for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
        end else if (we) begin
`ifdef RI_REG0_ZERO_EN
            if (wa != 5'd0) mdl[wa] = r;
`else
            mdl[wa] = r;
`endif
        end
        #1;
    endtask

    logic [3:0] op_tab [7] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, 4'b0011};

    initial begin
        rst = 1'b1; instruction = '0; ALU_OP = '0; RegWrite = 1'b0;
        RegDst = 1'b0; ALUSrc = 1'b0; XO = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) mdl[i] = 64'd0;

        step(0, 32'h7E000A14, OP_ADD, 0, 1, 1, "add_r16");
        chk("add_r16.const", last_res, 64'd0);
        step(0, mk(5'd0, 5'd16, 16'd0), OP_OR, 1, 1, 0, "read_r16");
        chk("read_r16.const", last_res, 64'd0);

        step(0, 32'h3A200014, OP_ADD, 1, 1, 1, "addi_r17");
        chk("addi_r17.const", last_res, 64'h14);
        step(0, mk(5'd0, 5'd17, 16'd0), OP_OR, 1, 1, 0, "read_r17");
        chk("read_r17.const", last_res, 64'd20);

        step(0, 32'h3A84FFFF, OP_ADD, 1, 1, 1, "addi_r20_m1");
        chk("addi_r20_m1.const", last_res, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_r20_m1.cout0", 64'(last_cout), 64'd0);
        chk("addi_r20_m1.ovf0", 64'(last_ovf), 64'd0);

        step(0, 32'h70D60000, OP_AND, 1, 0, 1, "andi_r22");
        chk("andi_r22.zero1", 64'(last_zero), 64'd1);

        step(0, mk(5'd17, 5'd0, 16'd99), OP_ADD, 1, 1, 0, "addi_r17_nowe");
        step(0, mk(5'd0, 5'd17, 16'd0), OP_OR, 1, 1, 0, "read_r17_kept");
        chk("read_r17_kept.const", last_res, 64'd20);
        step(0, mk(5'd31, 5'd17, {5'd17, 11'd0}), OP_SUB, 0, 1, 0, "sub_r17_r17");
        chk("sub_r17_r17.cout1", 64'(last_cout), 64'd1);
        chk("sub_r17_r17.zero1", 64'(last_zero), 64'd1);

        step(1, mk(5'd17, 5'd0, 16'd77), OP_ADD, 1, 1, 1, "rst_mid");
        step(0, mk(5'd0, 5'd17, 16'd0), OP_OR, 1, 1, 0, "read_r17_rst");
        chk("read_r17_rst.const", last_res, 64'd0);
        step(0, mk(5'd0, 5'd20, 16'd0), OP_OR, 1, 1, 0, "read_r20_rst");
        chk("read_r20_rst.const", last_res, 64'd0);

        step(0, mk(5'd5, 5'd0, 16'd1), OP_ADD, 1, 1, 1, "load_one");
        for (int i = 0; i < 63; i++) step(0, mk(5'd5, 5'd5, {5'd5, 11'd0}), OP_ADD, 0, 1, 1, "double");
        step(0, mk(5'd5, 5'd5, 16'd1), OP_SUB, 1, 1, 1, "make_max");
        chk("make_max.const", last_res, 64'h7FFF_FFFF_FFFF_FFFF);
        step(0, mk(5'd6, 5'd5, 16'd1), OP_ADD, 1, 1, 0, "ovf_add");
        chk("ovf_add.const", last_res, 64'h8000_0000_0000_0000);
        chk("ovf_add.ovf1", 64'(last_ovf), 64'd1);

        step(0, mk(5'd0, 5'd5, 16'd1), 4'b0011, 1, 1, 0, "bad_op");
        chk("bad_op.const", last_res, 64'd0);

        step(0, mk(5'd0, 5'd0, 16'd5), OP_ADD, 1, 1, 1, "write_r0");
        step(0, mk(5'd0, 5'd0, 16'd0), OP_OR, 1, 1, 0, "read_r0");
`ifdef RI_REG0_ZERO_EN
        chk("read_r0.const", last_res, 64'd0);
`else
        chk("read_r0.const", last_res, 64'd5);
`endif

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), $urandom, op_tab[$urandom_range(0, 6)],
                 1'($urandom), 1'($urandom), 1'($urandom), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
